// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared SNN types, saturation limits and clamp helpers
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        APPLY = 2'd2
    } state_e;

    // Clamp helpers work on a fixed 64-bit container so any neuron width up to 63 can share them.
    localparam int WIDE_W = 64;

    function automatic logic signed [WIDE_W-1:0] max_limit(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [WIDE_W-1:0] min_limit(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

    function automatic logic clamp_sat(input logic signed [WIDE_W-1:0] v, input int width);
        return (v > max_limit(width)) || (v < min_limit(width));
    endfunction

    function automatic logic signed [WIDE_W-1:0] clamp_value(input logic signed [WIDE_W-1:0] v,
                                                             input int width);
        if (v > max_limit(width)) begin
            return max_limit(width);
        end else if (v < min_limit(width)) begin
            return min_limit(width);
        end
        return v;
    endfunction

endpackage

// File: rtl/synapse_weight_rf.sv
// rtl/synapse_weight_rf.sv - per-input synaptic weight register file
module synapse_weight_rf
    import snn_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int N_IN  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we_i,
    input  logic [$clog2(N_IN)-1:0]    waddr_i,
    input  logic signed [WIDTH-1:0]    wdata_i,
    input  logic [$clog2(N_IN)-1:0]    raddr_i,
    output logic signed [WIDTH-1:0]    rdata_o
);

    localparam int AW = $clog2(N_IN);

    logic signed [WIDTH-1:0] mem_q [N_IN];
    logic                    addr_ok;

    // Addresses past the last input exist only when N_IN is not a power of two; such writes are dropped.
    if ((1 << AW) == N_IN) begin : g_pow2
        assign addr_ok = 1'b1;
    end else begin : g_npow2
        assign addr_ok = (int'(waddr_i) < N_IN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_IN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && addr_ok) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/synapse_current.sv
// rtl/synapse_current.sv - spike-to-current synapse with weighted sum, shift decay and saturation
module synapse_current
    import snn_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int N_IN        = 8,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic [N_IN-1:0]            spike_in,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [$clog2(N_IN)-1:0]    w_addr,
    input  logic signed [WIDTH-1:0]    w_data,
    output logic signed [WIDTH-1:0]    I_out,
    output logic                       busy,
    output logic                       done,
    output logic                       sat,
    output logic                       overrun
);

    localparam int AW    = $clog2(N_IN);
    localparam int ACC_W = WIDTH + AW + 1;
    localparam int NXT_W = WIDTH + AW + 2;
    localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);

    state_e                  state_q, state_d;
    logic [N_IN-1:0]         spk_q, spk_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [WIDTH-1:0] i_q, i_d;
    logic                    done_q, done_d;
    logic                    sat_q, sat_d;
    logic                    ovr_q, ovr_d;
    logic signed [WIDTH-1:0] w_rd;
    logic signed [NXT_W-1:0] i_next;
    logic                    w_fire;

    assign w_ready = rst_n && (state_q == IDLE);
    assign w_fire  = w_valid && w_ready;

    synapse_weight_rf #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (w_fire),
        .waddr_i (w_addr),
        .wdata_i (w_data),
        .raddr_i (idx_q),
        .rdata_o (w_rd)
    );

    // Arithmetic shift floors, so negative currents reach 0 while small positives stay put.
    assign i_next = NXT_W'(i_q) - NXT_W'(i_q >>> DECAY_SHIFT) + NXT_W'(acc_q);

    always_comb begin
        state_d = state_q;
        spk_d   = spk_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        i_d     = i_q;
        done_d  = 1'b0;
        sat_d   = sat_q;
        ovr_d   = ovr_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    spk_d   = spike_in;
                    idx_d   = '0;
                    acc_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (spk_q[idx_q]) begin
                    acc_d = acc_q + ACC_W'(w_rd);
                end
                idx_d = idx_q + AW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                i_d     = WIDTH'(clamp_value(WIDE_W'(i_next), WIDTH));
                sat_d   = clamp_sat(WIDE_W'(i_next), WIDTH);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (tick && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            spk_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            spk_q   <= spk_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            done_q  <= done_d;
            sat_q   <= sat_d;
            ovr_q   <= ovr_d;
        end
    end

    assign I_out   = i_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign sat     = sat_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_synapse_current.sv
// tb/tb_synapse_current.sv - self-checking bench for synapse_current
module tb_synapse_current;

    localparam int WIDTH = 16;
    localparam int N_IN  = 8;
    localparam int DS    = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    tick;
    logic [N_IN-1:0]         spike_in;
    logic                    w_valid;
    logic                    w_ready;
    logic [2:0]              w_addr;
    logic signed [WIDTH-1:0] w_data;
    logic signed [WIDTH-1:0] I_out;
    logic                    busy;
    logic                    done;
    logic                    sat;
    logic                    overrun;

    int n_cmp = 0;
    int n_bad = 0;

    synapse_current #(
        .WIDTH       (WIDTH),
        .N_IN        (N_IN),
        .DECAY_SHIFT (DS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .spike_in (spike_in),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .I_out    (I_out),
        .busy     (busy),
        .done     (done),
        .sat      (sat),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an update is a countdown of N_IN+1 edges after the tick, then I = clamp(I - floor(I/2^DS) + sum).
    longint w_m [N_IN];
    longint i_m = 0;
    longint pend_sum = 0;
    int     left = 0;
    bit     e_done = 0, e_sat = 0, e_ovr = 0;

    function automatic longint floor_div(input longint a, input longint b);
        return (a >= 0) ? a / b : -((-a + b - 1) / b);
    endfunction

    always @(posedge clk) begin
        longint v;
        e_done = 0;
        if (!rst_n) begin
            foreach (w_m[k]) w_m[k] = 0;
            i_m = 0; left = 0; e_sat = 0; e_ovr = 0;
        end else if (left > 0) begin
            if (tick) e_ovr = 1;
            left--;
            if (left == 0) begin
                v = i_m - floor_div(i_m, 2 ** DS) + pend_sum;
                e_sat = 0;
                if (v > 32767) begin v = 32767; e_sat = 1; end
                if (v < -32768) begin v = -32768; e_sat = 1; end
                i_m = v;
                e_done = 1;
            end
        end else begin
            if (w_valid) w_m[w_addr] = w_data;
            if (tick) begin
                pend_sum = 0;
                for (int k = 0; k < N_IN; k++) if (spike_in[k]) pend_sum += w_m[k];
                left = N_IN + 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("I_out", I_out, i_m);
        check("busy", busy, longint'(left > 0));
        check("done", done, e_done);
        check("sat", sat, e_sat);
        check("overrun", overrun, e_ovr);
        check("w_ready", w_ready, longint'(rst_n && left == 0));
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic do_tick(input logic [N_IN-1:0] s, output int lat);
        @(negedge clk);
        tick = 1; spike_in = s;
        @(posedge clk); #1;
        tick = 0; spike_in = ~s;
        wait_done(lat);
    endtask

    task automatic write_w(input int a, input longint d, output int waited, output logic busy_at);
        logic [2:0]  a3;
        logic [15:0] d16;
        a3 = a[2:0]; d16 = d[15:0];
        waited = 0;
        @(negedge clk);
        w_valid = 1; w_addr = a3; w_data = d16;
        while (!w_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("write_ready", w_ready, 1);
        busy_at = busy;
        @(posedge clk); #1;
        w_valid = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int   lat, wt;
        logic b;
        rst_n = 0; tick = 0; w_valid = 0; spike_in = '0; w_addr = '0; w_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_I", I_out, 0);
        check("rst_ready", w_ready, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        check("rel_ready", w_ready, 1);

        write_w(3, 1000, wt, b);
        do_tick(8'h08, lat);
        check("latency", lat, 9);
        check("I_1000", I_out, 1000);
        check("model_1000", i_m, 1000);
        check("sat_0", sat, 0);
        do_tick(8'h00, lat);
        check("I_938", I_out, 938);
        do_tick(8'h00, lat);
        check("I_880", I_out, 880);
        check("model_880", i_m, 880);

        for (int k = 0; k < N_IN; k++) write_w(k, 30000, wt, b);
        do_tick(8'hFF, lat);
        check("I_pos_sat", I_out, 32767);
        check("sat_pos", sat, 1);
        for (int k = 0; k < N_IN; k++) write_w(k, -30000, wt, b);
        do_tick(8'hFF, lat);
        check("I_neg_sat", I_out, -32768);
        check("sat_neg", sat, 1);

        write_w(0, 30719, wt, b);
        do_tick(8'h01, lat);
        check("I_m1", I_out, -1);
        do_tick(8'h00, lat);
        check("I_neg_decay0", I_out, 0);
        check("model_0", i_m, 0);

        @(negedge clk);
        tick = 1; spike_in = 8'h01;
        @(posedge clk); #1;
        tick = 0; spike_in = 8'hFF;
        repeat (3) @(negedge clk);
        tick = 1;
        @(posedge clk); #1;
        tick = 0;
        wait_done(lat);
        check("I_overrun", I_out, 30719);
        check("overrun_set", overrun, 1);

        @(negedge clk);
        tick = 1; spike_in = 8'h00;
        @(posedge clk); #1;
        tick = 0;
        write_w(1, 100, wt, b);
        check("wr_waited", longint'(wt > 0), 1);
        check("wr_idle", b, 0);
        check("I_28800", I_out, 28800);

        @(negedge clk);
        w_valid = 1; w_addr = 3'd0; w_data = 16'sd500; tick = 1; spike_in = 8'h01;
        @(posedge clk); #1;
        w_valid = 0; tick = 0;
        wait_done(lat);
        check("I_27500", I_out, 27500);

        @(negedge clk);
        tick = 1; spike_in = 8'hFF;
        @(posedge clk); #1;
        tick = 0;
        repeat (3) @(negedge clk);
        rst_n = 0;
        @(posedge clk); #1;
        check("midrst_I", I_out, 0);
        check("midrst_done", done, 0);
        check("midrst_ovr", overrun, 0);
        @(negedge clk) rst_n = 1;
        do_tick(8'hFF, lat);
        check("post_rst_I", I_out, 0);
        check("post_rst_sat", sat, 0);

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
